// File: rtl/io_bit_sequencer.sv
// io_bit_sequencer
//   Runs the multi-cycle AVR I/O bit instructions (SBI, CBI, SBIS, SBIC) and
//   the register skip instructions (SBRS, SBRC). It sits between the
//   instruction decoder and the bit processor. It produces:
//     - the I/O read cycle and the SBI/CBI write-back cycle;
//     - the 1- or 2-word skip, which replaces fetched words with NOPs.
//
// Ports
//   cp2              in   core clock, rising edge
//   ireset           in   asynchronous active-low reset
//   cp2en            in   clock enable for state and latches
//   instruction[15:0] in  decoded word, A = [7:3], b = [2:0]
//   idc_sbi .. idc_sbrc in decoder strobes (at most one high)
//   next_inst_2word  in   word behind the current one starts a 2-word instruction
//   bit_test_op_out  in   bit test result from the bit processor
//   adr[5:0]         out  I/O address
//   iore / iowe      out  I/O read / write strobes
//   sbi_st / cbi_st  out  write-back state to the bit processor
//   bit_num_r_io[2:0] out bit number to the bit processor
//   pc_hold          out  freeze PC/fetch
//   skip_nop         out  substitute NOP for the word in decode
//   seq_busy         out  sequencer not idle (inhibits interrupt acceptance)
//
// state    | meaning
// S_IDLE   | decode cycle; outputs follow the decoder strobes
// S_RMW_WR | SBI/CBI write-back of the latched address and bit
// S_SKIP1  | first skipped word is replaced by a NOP
// S_SKIP2  | second word of a skipped 2-word instruction is replaced by a NOP
module io_bit_sequencer (
  input  logic        cp2,
  input  logic        ireset,
  input  logic        cp2en,
  input  logic [15:0] instruction,
  input  logic        idc_sbi,
  input  logic        idc_cbi,
  input  logic        idc_sbis,
  input  logic        idc_sbic,
  input  logic        idc_sbrs,
  input  logic        idc_sbrc,
  input  logic        next_inst_2word,
  input  logic        bit_test_op_out,
  output logic [5:0]  adr,
  output logic        iore,
  output logic        iowe,
  output logic        sbi_st,
  output logic        cbi_st,
  output logic [2:0]  bit_num_r_io,
  output logic        pc_hold,
  output logic        skip_nop,
  output logic        seq_busy
);

  typedef enum logic [1:0] {S_IDLE, S_RMW_WR, S_SKIP1, S_SKIP2} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_a, w_a_nxt;
  logic [2:0] r_b, w_b_nxt;
  logic       r_is_sbi, w_is_sbi_nxt;
  logic       r_skip2, w_skip2_nxt;

  logic [5:0] w_adr;
  logic       w_iore, w_iowe, w_sbi_st, w_cbi_st;
  logic [2:0] w_bit_num;
  logic       w_pc_hold, w_skip_nop, w_seq_busy;

  logic       w_io_strobe;
  logic       w_rmw_strobe;
  logic       w_skip_strobe;

  assign w_io_strobe   = idc_sbi | idc_cbi | idc_sbis | idc_sbic;
  assign w_rmw_strobe  = idc_sbi | idc_cbi;
  assign w_skip_strobe = idc_sbis | idc_sbic | idc_sbrs | idc_sbrc;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_is_sbi <= 1'b0;
      r_skip2  <= 1'b0;
    end else if (cp2en) begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_is_sbi <= w_is_sbi_nxt;
      r_skip2  <= w_skip2_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_is_sbi_nxt = r_is_sbi;
    w_skip2_nxt  = r_skip2;
    w_adr        = '0;
    w_iore       = 1'b0;
    w_iowe       = 1'b0;
    w_sbi_st     = 1'b0;
    w_cbi_st     = 1'b0;
    w_bit_num    = '0;
    w_pc_hold    = 1'b0;
    w_skip_nop   = 1'b0;
    w_seq_busy   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_bit_num = instruction[2:0];
        w_adr     = w_io_strobe ? {1'b0, instruction[7:3]} : 6'd0;
        w_iore    = w_io_strobe;
        w_pc_hold = w_rmw_strobe;
        // SBI/CBI win over the skip strobes if the decoder ever raises two.
        if (w_rmw_strobe) begin
          w_a_nxt      = instruction[7:3];
          w_b_nxt      = instruction[2:0];
          w_is_sbi_nxt = idc_sbi;
          w_state_nxt  = S_RMW_WR;
        end else if (w_skip_strobe && bit_test_op_out) begin
          w_skip2_nxt = next_inst_2word;
          w_state_nxt = S_SKIP1;
        end
      end
      S_RMW_WR: begin
        w_adr       = {1'b0, r_a};
        w_bit_num   = r_b;
        w_iowe      = 1'b1;
        w_sbi_st    = r_is_sbi;
        w_cbi_st    = !r_is_sbi;
        w_seq_busy  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_SKIP1: begin
        w_skip_nop  = 1'b1;
        w_seq_busy  = 1'b1;
        w_state_nxt = r_skip2 ? S_SKIP2 : S_IDLE;
      end
      S_SKIP2: begin
        w_skip_nop  = 1'b1;
        w_seq_busy  = 1'b1;
        w_skip2_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The IDLE outputs are combinational from the decoder strobes. Gating with
  // ireset keeps every output at 0 while reset is asserted, without waiting
  // for a clock edge.
  assign adr          = ireset ? w_adr      : 6'd0;
  assign iore         = ireset & w_iore;
  assign iowe         = ireset & w_iowe;
  assign sbi_st       = ireset & w_sbi_st;
  assign cbi_st       = ireset & w_cbi_st;
  assign bit_num_r_io = ireset ? w_bit_num  : 3'd0;
  assign pc_hold      = ireset & w_pc_hold;
  assign skip_nop     = ireset & w_skip_nop;
  assign seq_busy     = ireset & w_seq_busy;

endmodule
